cayde_core_ctrl: RTL and testbench

Multi-cycle sequencer for the cayde RV32I core. Owns PC and instruction register and drives the fetch/decode/execute/memory/writeback sequence around the decoder, ALU and register file. Handles the instruction- and data-memory request/grant/rvalid handshakes and steers illegal instructions. One instruction in flight at a time; no pipelining.

---
 rtl/cayde_core_ctrl.sv | 138 +++++++++++++
 tb/tb_cayde_core_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cayde_core_ctrl.sv
// Multi-cycle FETCH..NEXT sequencer for the cayde RV32I core: owns PC/IR and the memory handshakes.
// Define CAYDE_TRAP_EN to vector illegal instructions to TRAP_VEC; otherwise they retire as NOPs.
module cayde_core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic        illegal_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic        alu_en,
  output logic        rf_we,
  output logic        retire,
  output logic        trap_o
);

`ifdef CAYDE_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [31:0] NopInstr = 32'h0000_0013;
  localparam logic [6:0]  OpR      = 7'b0110011;
  localparam logic [6:0]  OpImm    = 7'b0010011;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpLui    = 7'b0110111;

  typedef enum logic [2:0] {
    S_FETCH, S_IWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_NEXT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, is_jal, legal_op, take_illegal;

  assign opcode       = ir_q[6:0];
  assign is_load      = (opcode == OpLoad);
  assign is_store     = (opcode == OpStore);
  assign is_branch    = (opcode == OpBranch);
  assign is_jal       = (opcode == OpJal);
  assign legal_op     = (opcode == OpR) || (opcode == OpImm) || is_load || is_store ||
                        is_branch || is_jal || (opcode == OpLui);
  assign take_illegal = illegal_in || !legal_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NopInstr;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (imem_gnt) state_d = S_IWAIT;
      // rvalid is only meaningful once the grant has been taken
      S_IWAIT: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal_d = take_illegal;
        if (take_illegal) begin
          if (TrapEn) begin
            pc_d    = TRAP_VEC;
            state_d = S_FETCH;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_NEXT;
        else                     state_d = S_WB;
      end
      S_MEM:    if (dmem_gnt) state_d = is_store ? S_NEXT : S_MWAIT;
      S_MWAIT:  if (dmem_rvalid) state_d = S_WB;
      S_WB:     state_d = S_NEXT;
      // an instruction demoted to a NOP must not redirect even with a branch opcode
      S_NEXT: begin
        if (branch_taken && (is_branch || is_jal) && !illegal_q) pc_d = branch_target;
        else                                                     pc_d = pc_q + 32'd4;
        state_d = S_FETCH;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = rst_n && (state_q == S_FETCH);
    dmem_req = (state_q == S_MEM);
    dmem_we  = (state_q == S_MEM) && is_store;
    alu_en   = (state_q == S_EXEC);
    rf_we    = (state_q == S_WB);
    retire   = (state_q == S_NEXT);
    trap_o   = TrapEn && (state_q == S_DECODE) && take_illegal;
  end

  assign imem_addr = pc_q;
  assign pc_o      = pc_q;
  assign ir_o      = ir_q;

endmodule

// File: tb/tb_cayde_core_ctrl.sv
// Bench for cayde_core_ctrl: table of instructions with scoreboarded completion checks plus reset corner cases.
// Expected values follow CAYDE_TRAP_EN the same way the design does.
module tb_cayde_core_ctrl;

`ifdef CAYDE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int          BUDGET = 60;
  localparam logic [31:0] PC3    = TRAP ? 32'h0000_0100 : 32'h0000_000C;
  localparam logic [31:0] PCL    = TRAP ? 32'h0000_0100 : 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic        illegal_in = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc_o, ir_o;
  logic        alu_en, rf_we, retire, trap_o;

  cayde_core_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .illegal_in(illegal_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_o(pc_o), .ir_o(ir_o), .alu_en(alu_en), .rf_we(rf_we), .retire(retire), .trap_o(trap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        illegal;
    logic        taken;
    logic [31:0] target;
    int          igd, ird, dgd, drd;
    bit          rv_with_gnt;
    logic [31:0] npc;
    int          alu, rf, dreq;
    logic        dwe, ret, trp;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic ill, input logic tk,
                              input logic [31:0] tgt, input int igd, input int ird,
                              input int dgd, input int drd, input bit rvg,
                              input logic [31:0] npc, input int alu, input int rf,
                              input int dreq, input logic dwe, input logic ret, input logic trp);
    vec_t v;
    v.instr = instr; v.illegal = ill; v.taken = tk; v.target = tgt;
    v.igd = igd; v.ird = ird; v.dgd = dgd; v.drd = drd; v.rv_with_gnt = rvg;
    v.npc = npc; v.alu = alu; v.rf = rf; v.dreq = dreq; v.dwe = dwe; v.ret = ret; v.trp = trp;
    return v;
  endfunction

  // Completion monitor: counts strobes per instruction and checks the popped record once the PC has updated.
  initial begin
    int n_alu, n_rf, n_dreq, s_alu, s_rf, s_dreq;
    logic dwe_seen, s_dwe, s_ret, s_trp;
    bit pend;
    vec_t e;
    n_alu = 0; n_rf = 0; n_dreq = 0; dwe_seen = 1'b0; pend = 0;
    s_alu = 0; s_rf = 0; s_dreq = 0; s_dwe = 1'b0; s_ret = 1'b0; s_trp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_alu = 0; n_rf = 0; n_dreq = 0; dwe_seen = 1'b0; pend = 0;
      end else begin
        if (pend) begin
          pend = 0;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            $display("[TB] instr %h done: pc_o=%h ret=%0b trap=%0b alu=%0d rf=%0d dreq=%0d",
                     e.instr, pc_o, s_ret, s_trp, s_alu, s_rf, s_dreq);
            check("next_pc", pc_o, e.npc);
            check("retire", 32'(s_ret), 32'(e.ret));
            check("trap", 32'(s_trp), 32'(e.trp));
            check("alu_en_cnt", s_alu, e.alu);
            check("rf_we_cnt", s_rf, e.rf);
            check("dmem_req_cycles", s_dreq, e.dreq);
            check("dmem_we", 32'(s_dwe), 32'(e.dwe));
          end
        end
        n_alu += int'(alu_en);
        n_rf += int'(rf_we);
        n_dreq += int'(dmem_req);
        if (dmem_req && dmem_we) dwe_seen = 1'b1;
        if (retire || trap_o) begin
          s_alu = n_alu; s_rf = n_rf; s_dreq = n_dreq; s_dwe = dwe_seen;
          s_ret = retire; s_trp = trap_o;
          n_alu = 0; n_rf = 0; n_dreq = 0; dwe_seen = 1'b0;
          pend = 1;
        end
      end
    end
  end

  // Plays the memory side of one instruction; lat is cycles from FETCH entry to retire/trap.
  task automatic run_instr(input vec_t v, input logic [31:0] exp_pc, output int lat);
    int t;
    lat = 0;
    illegal_in = v.illegal; branch_taken = v.taken; branch_target = v.target;
    sb.push_back(v);
    t = 0;
    while (!imem_req && t < BUDGET) begin @(negedge clk); t++; end
    if (!imem_req) begin check("fetch_timeout", 32'd0, 32'd1); return; end
    check("imem_addr", imem_addr, exp_pc);
    repeat (v.igd) begin @(negedge clk); lat++; end
    check("imem_req_hold", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    if (v.rv_with_gnt) begin imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF; end
    @(negedge clk); lat++;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    check("imem_req_drop", 32'(imem_req), 32'd0);
    repeat (v.ird) begin @(negedge clk); lat++; end
    imem_rvalid = 1'b1; imem_rdata = v.instr;
    @(negedge clk); lat++;
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    if (v.dreq > 0) begin
      t = 0;
      while (!dmem_req && t < BUDGET) begin @(negedge clk); lat++; t++; end
      if (!dmem_req) begin check("dmem_timeout", 32'd0, 32'd1); return; end
      repeat (v.dgd) begin @(negedge clk); lat++; end
      dmem_gnt = 1'b1;
      @(negedge clk); lat++;
      dmem_gnt = 1'b0;
      if (!v.dwe) begin
        repeat (v.drd) begin
          check("rf_we_before_rvalid", 32'(rf_we), 32'd0);
          @(negedge clk); lat++;
        end
        dmem_rvalid = 1'b1;
        @(negedge clk); lat++;
        dmem_rvalid = 1'b0;
      end
    end
    t = 0;
    while (!(retire || trap_o) && t < BUDGET) begin @(negedge clk); lat++; t++; end
    if (!(retire || trap_o)) begin check("done_timeout", 32'd0, 32'd1); return; end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] cur_pc;
    //              instr          ill   tk    target        igd ird dgd drd rvg npc           alu rf dreq dwe   ret    trp
    vecs[0]  = mk(32'h002081B3, 1'b0, 1'b0, 32'h0,          1, 1, 0, 0, 0, 32'h4,         1, 1, 0, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(32'h0000A103, 1'b0, 1'b0, 32'h0,          0, 0, 3, 2, 0, 32'h8,         1, 1, 4, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,          0, 0, 0, 0, 0, PC3,           0, 0, 0, 1'b0, !TRAP, TRAP);
    vecs[3]  = mk(32'h00208463, 1'b0, 1'b1, 32'h40,         0, 0, 0, 0, 0, 32'h40,        1, 0, 0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(32'h00208463, 1'b0, 1'b0, 32'h80,         0, 0, 0, 0, 0, 32'h44,        1, 0, 0, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(32'h0020A023, 1'b0, 1'b0, 32'h0,          0, 0, 1, 0, 0, 32'h48,        1, 0, 2, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(32'h008000EF, 1'b0, 1'b1, 32'h200,        0, 0, 0, 0, 0, 32'h200,       1, 1, 0, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(32'h002081B3, 1'b0, 1'b1, 32'h300,        0, 1, 0, 0, 1, 32'h204,       1, 1, 0, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mk(32'h123450B7, 1'b0, 1'b0, 32'h0,          2, 1, 0, 0, 0, 32'h208,       1, 1, 0, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(32'h00208463, 1'b0, 1'b1, 32'hFFFFFFFC,   0, 0, 0, 0, 0, 32'hFFFFFFFC,  1, 0, 0, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(32'h00100093, 1'b0, 1'b0, 32'h0,          0, 0, 0, 0, 0, 32'h0,         1, 1, 0, 1'b0, 1'b1, 1'b0);
    vecs[11] = mk(32'h00100093, 1'b1, 1'b0, 32'h0,          0, 0, 0, 0, 0, PCL,           0, 0, 0, 1'b0, !TRAP, TRAP);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_pc", pc_o, 32'h0);
    check("rst_ir", ir_o, 32'h0000_0013);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_strobes", {26'd0, dmem_req, alu_en, rf_we, retire, trap_o, dmem_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_imem_addr", imem_addr, 32'h0);

    cur_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i], cur_pc, lat);
      $display("[TB] vec %0d instr %h at pc %h latency %0d", i, vecs[i].instr, cur_pc, lat);
      if (i == 0) check("add_latency", lat, 7);
      cur_pc = vecs[i].npc;
    end

    // reset while a load sits in MWAIT, then a stale rvalid after release
    illegal_in = 1'b0; branch_taken = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000A103;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int t = 0; t < BUDGET && !dmem_req; t++) @(negedge clk);
    check("mw_dmem_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mw_rst_pc", pc_o, 32'h0);
    check("mw_rst_ir", ir_o, 32'h0000_0013);
    check("mw_rst_imem_req", 32'(imem_req), 32'd0);
    check("mw_rst_dmem_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; dmem_rvalid = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      $display("[TB] post-reset idle cycle %0d: imem_req=%0b pc_o=%h rf_we=%0b", c, imem_req, pc_o, rf_we);
      check("stale_imem_req", 32'(imem_req), 32'd1);
      check("stale_pc", pc_o, 32'h0);
      check("stale_rf_we", 32'(rf_we), 32'd0);
      @(negedge clk);
    end
    run_instr(vecs[0], 32'h0, lat);
    $display("[TB] post-reset add latency %0d", lat);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

endmodule
